phy_pattern_gen: RTL
====================

# phy_pattern_gen

Parametrised, synthesizable multi-lane symbol stimulus generator for the PCIe physical-layer datapath. It drives the lane inputs of the phy block under test. On request it emits COM idle symbols, then a programmable payload burst with per-lane valid, then returns to idle. It replaces hand-written lane stimulus with a block that supports any lane count and symbol width, three payload modes, and abort.

## Interface
- LANES, 4, number of lanes (>=1)
- WIDTH, 8, symbol width in bits (>=2)
- COM_SYMBOL, 8'hBC, idle/sync symbol, truncated/zero-extended to WIDTH
- SYNC_CYCLES, 10, COM cycles before payload (0 allowed = skip SYNC)
- PAYLOAD_LEN, 8, payload beats per burst (>=1)
- STEP, 8'h11, per-symbol decrement for mode 1
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  burst request, sampled only in IDLE
- stop  input  1  abort request, sampled in every state
- mode  input  2  payload mode, sampled with start
- pattern  input  LANES*WIDTH  static payload for mode 2, sampled with start
- out  output  LANES*WIDTH  lane symbols, lane i at bits [i*WIDTH +: WIDTH]
- valid_out  output  LANES  per-lane valid
- busy  output  1  high in SYNC and DATA
- done  output  1  one-cycle pulse when a burst completes normally

## Operation
- All outputs registered. Reset value: every lane of out = COM_SYMBOL, valid_out = 0, busy = 0, done = 0, state IDLE, counters 0, latched mode/pattern 0.
- States: IDLE, SYNC, DATA, DONE.
- IDLE: out = COM on all lanes, valid_out = 0. If start=1 and stop=0: latch mode and pattern. Go to SYNC, or to DATA when SYNC_CYCLES=0.
- SYNC: out = COM, valid_out = 0, busy = 1. Lasts exactly SYNC_CYCLES cycles, then DATA.
- DATA: valid_out = all ones, busy = 1. Lasts exactly PAYLOAD_LEN beats (k = 0..PAYLOAD_LEN-1), then DONE.
- DONE: out = COM, valid_out = 0, busy = 0, done = 1 for one cycle, then IDLE. A start during DONE is ignored.
- Payload for beat k, lane i, with n = k*LANES + i and all arithmetic mod 2^WIDTH:
  - mode 0: n
  - mode 1: (2^WIDTH-1) - STEP*n
  - mode 2: latched pattern lane i, identical every beat
  - mode 3: reserved, behaves as mode 0
- No escaping: a payload symbol equal to COM_SYMBOL is emitted as-is.
- stop=1 in SYNC or DATA: next edge goes to IDLE with COM/valid 0. No done pulse; counters clear.
- stop=1 in DONE: done pulse still completes, then IDLE.
- start and stop both high in IDLE: stop wins, stay IDLE.
- start while busy: ignored, not queued.
- Counter widths: $clog2 of max(SYNC_CYCLES, PAYLOAD_LEN)+1. The symbol index n is a WIDTH-bit wrapping accumulator incremented by LANES per beat.

## Timing
- start high at edge t (IDLE): from edge t, busy=1 and SYNC outputs appear.
- First valid beat appears at edge t+SYNC_CYCLES. Last beat at t+SYNC_CYCLES+PAYLOAD_LEN-1.
- done=1 for edge t+SYNC_CYCLES+PAYLOAD_LEN to the next edge.
- Earliest restart: start sampled in the IDLE cycle after DONE. Minimum burst period = SYNC_CYCLES+PAYLOAD_LEN+2 cycles.
- stop sampled at edge s: outputs are IDLE values from edge s.
- Reset asserted mid-burst: outputs go to reset values without waiting for clk. The first start is accepted on the first edge after deassertion.

## Test plan
- Defaults, mode 1, start one cycle: 10 cycles COM 0xBC/valid 0. Beat0 lanes0..3 = FF,EE,DD,CC. Beat1 = BB,AA,99,88. Beat2 = 77,66,55,44. Eight beats total with valid_out=4'hF, then done pulse, then IDLE.
- Mode 0, WIDTH=8, LANES=4, PAYLOAD_LEN=70: beat 63 = FC,FD,FE,FF; beat 64 wraps to 00,01,02,03.
- Mode 2, pattern=32'h8899AABB; pattern input changed to 0 after start: all 8 beats still BB,AA,99,88 on lanes 0..3.
- stop at DATA beat 3: valid_out=0 and out=COM from that edge, busy=0, no done pulse. Start asserted during the burst is ignored; start after stop gives a full new burst from beat 0.
- Reset asserted asynchronously mid-SYNC and mid-DATA: outputs immediately COM/0/0/0. start with stop both high in IDLE: no burst.
- SYNC_CYCLES=0, PAYLOAD_LEN=1, LANES=1: start at edge t gives one valid beat at t, done at t+1. Back-to-back starts give period 3 cycles.

Source files
------------

// File: rtl/phy_pattern_gen.sv
// Multi-lane PHY symbol stimulus generator: COM preamble, payload burst, done pulse.
// State | meaning: IDLE wait for start | SYNC COM preamble | DATA payload beats | DONE done pulse
module phy_pattern_gen #(
    parameter int          LANES       = 4,
    parameter int          WIDTH       = 8,
    parameter int unsigned COM_SYMBOL  = 8'hBC,
    parameter int          SYNC_CYCLES = 10,
    parameter int          PAYLOAD_LEN = 8,
    parameter int unsigned STEP        = 8'h11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] pattern,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       valid_out,
    output logic                   busy,
    output logic                   done
);

    localparam int MAXC = (SYNC_CYCLES > PAYLOAD_LEN) ? SYNC_CYCLES : PAYLOAD_LEN;
    localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;
    localparam logic [WIDTH-1:0] COM       = WIDTH'(COM_SYMBOL);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LANES_W   = WIDTH'(LANES);
    localparam logic [CW-1:0]    SYNC_LOAD = CW'((SYNC_CYCLES > 0) ? SYNC_CYCLES - 1 : 0);
    localparam logic [CW-1:0]    DATA_LOAD = CW'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [WIDTH-1:0]       n_base, n_nx;
    logic [1:0]             mode_q, mode_eff;
    logic [LANES*WIDTH-1:0] pattern_q, pattern_eff;
    logic                   accept;

    logic [LANES*WIDTH-1:0] out_nx;
    logic [LANES-1:0]       valid_nx;
    logic                   busy_nx, done_nx;
    logic [WIDTH-1:0]       idx, sym;

    assign accept      = (state == IDLE) && start && !stop;
    // The payload of a burst that skips SYNC is computed from the live inputs.
    assign mode_eff    = (state == IDLE) ? mode : mode_q;
    assign pattern_eff = (state == IDLE) ? pattern : pattern_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            n_base    <= '0;
            mode_q    <= '0;
            pattern_q <= '0;
            out       <= {LANES{COM}};
            valid_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            n_base    <= n_nx;
            out       <= out_nx;
            valid_out <= valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            if (accept) begin
                mode_q    <= mode;
                pattern_q <= pattern;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_nx     = n_base;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                n_nx   = '0;
                if (accept) begin
                    if (SYNC_CYCLES == 0) begin
                        state_nx = DATA;
                        cnt_nx   = DATA_LOAD;
                    end else begin
                        state_nx = SYNC;
                        cnt_nx   = SYNC_LOAD;
                    end
                end
            end
            SYNC: begin
                if (stop) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    n_nx     = '0;
                end else if (cnt == '0) begin
                    state_nx = DATA;
                    cnt_nx   = DATA_LOAD;
                    n_nx     = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DATA: begin
                if (stop || cnt == '0) begin
                    state_nx = stop ? IDLE : DONE;
                    cnt_nx   = '0;
                    n_nx     = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    n_nx   = n_base + LANES_W;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                n_nx     = '0;
            end
        endcase
    end

    always_comb begin
        out_nx   = {LANES{COM}};
        valid_nx = '0;
        busy_nx  = (state_nx == SYNC) || (state_nx == DATA);
        done_nx  = (state_nx == DONE);
        idx      = '0;
        sym      = '0;
        if (state_nx == DATA) begin
            valid_nx = '1;
            for (int i = 0; i < LANES; i++) begin
                idx = n_nx + WIDTH'(i);
                case (mode_eff)
                    2'd1:    sym = '1 - STEP_W * idx;
                    2'd2:    sym = pattern_eff[i*WIDTH +: WIDTH];
                    default: sym = idx;
                endcase
                out_nx[i*WIDTH +: WIDTH] = sym;
            end
        end
    end

endmodule
